// File: rtl/instr_fetch_unit.sv
// PC register and instruction-fetch front end: one outstanding imem request, out reg plus skid buffer, redirects.
// Build option: define FETCH_MISALIGN_CHECK_EN to fault on misaligned redirect targets instead of masking them.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [24:0] raw_src,
  output logic        fetch_fault
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RAW_W = 25;
  localparam int unsigned RAW_LSB = XLEN - RAW_W;

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_ent_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;
  logic            out_valid_q, out_valid_d;
  fetch_ent_t      out_q, out_d;
  logic            skid_valid_q, skid_valid_d;
  fetch_ent_t      skid_q, skid_d;
  logic            drop_q, drop_d;
  logic            fault_q, fault_d;

  logic            accept;
  logic            consume;
  logic            rsp_keep;
  logic [XLEN-1:0] target_aligned;
  fetch_ent_t      rsp_ent;

  assign accept         = req_valid_q & imem_req_ready;
  assign consume        = out_valid_q & ~stall;
  assign rsp_keep       = (state_q == ST_WAIT) & imem_rsp_valid & ~drop_q;
  assign target_aligned = redirect_target & ~XLEN'(3);
  assign rsp_ent        = '{pc: req_pc_q, word: imem_rsp_data};

  // Next-state: buffer movement, request FSM, then redirect overrides.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    drop_d       = drop_q;
    fault_d      = fault_q;

    if (consume) begin
      out_valid_d  = skid_valid_q;
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end

    if (rsp_keep) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_d       = rsp_ent;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = rsp_ent;
      end
    end

    case (state_q)
      ST_REQ: begin
        if (accept) begin
          state_d  = ST_WAIT;
          pc_d     = pc_q + XLEN'(4);
          req_pc_d = pc_q;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // An in-flight request stays owed to memory; its response is discarded via drop.
    if (redirect) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = target_aligned;
      if ((state_q == ST_WAIT && !imem_rsp_valid) || (state_q == ST_REQ && accept)) begin
        drop_d = 1'b1;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
`endif
    end

    req_valid_d = (state_d == ST_REQ) & ~skid_valid_d & ~fault_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      req_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      drop_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      drop_q       <= drop_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = out_valid_q;
  assign instr          = out_q.word;
  assign instr_pc       = out_q.pc;
  assign raw_src        = out_q.word[XLEN-1:RAW_LSB];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
// Checks the misaligned-redirect behaviour for whichever FETCH_MISALIGN_CHECK_EN setting is built.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [24:0] raw_src;
  logic        fetch_fault;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .stall           (stall),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .raw_src         (raw_src),
    .fetch_fault     (fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] raw;
  } vec_t;

  vec_t        vecs [8];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 1;
  logic        pend     = 1'b0;
  logic [31:0] paddr    = '0;
  int          pcnt     = 0;
  logic [31:0] got_pc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One clock: memory sees accepts and decode consumes before the edge, response driven after it.
  task automatic step();
    logic [31:0] w;
    if (imem_req_valid && imem_req_ready) begin
      pend  = 1'b1;
      paddr = imem_addr;
      pcnt  = lat - 1;
    end
    if (instr_valid && !stall) begin
      got_pc.push_back(instr_pc);
      w = mem_word(instr_pc);
      chk("mon_instr", instr, w);
      chk("mon_raw_src", 32'(raw_src), 32'(w[31:7]));
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(paddr);
        pend           = 1'b0;
      end else begin
        pcnt--;
      end
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    stall          = 1'b0;
    imem_rsp_valid = 1'b0;
    pend           = 1'b0;
    #3;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_raw_src", 32'(raw_src), 32'h0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_pc.delete();
  endtask

  task automatic wait_req(input string name, input int max);
    int i = 0;
    while (!imem_req_valid && i < max) begin
      step();
      i++;
    end
    if (!imem_req_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no request within %0d cycles", name, max);
    end
  endtask

  task automatic chk_first(input string name, input logic [31:0] exp);
    if (got_pc.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no instruction consumed, expected pc 0x%08h", name, exp);
    end else begin
      chk(name, got_pc[0], exp);
    end
  endtask

  initial begin
    int cnt8;
    int i;
    rst_n           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_rsp_data   = '0;
    imem_rsp_valid  = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    stall           = 1'b0;

    //             stall req  addr    iv   pc     raw
    vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0000_A001};
    vecs[4] = '{1'b0, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h0000_0800};
    vecs[6] = '{1'b0, 1'b0, 32'hC, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 32'h0000_1000};

    #1;
    do_reset();

    // Straight-line fetch, zero-wait memory.
    for (int v = 0; v < 8; v++) begin
      stall = vecs[v].stall;
      chk($sformatf("v%0d_req_valid", v), 32'(imem_req_valid), 32'(vecs[v].req));
      chk($sformatf("v%0d_addr", v), imem_addr, vecs[v].addr);
      chk($sformatf("v%0d_instr_valid", v), 32'(instr_valid), 32'(vecs[v].iv));
      if (vecs[v].iv) begin
        chk($sformatf("v%0d_instr_pc", v), instr_pc, vecs[v].pc);
        chk($sformatf("v%0d_raw_src", v), 32'(raw_src), vecs[v].raw);
      end
      step();
    end

    // Stall: out holds word0, skid word1, requests gated until skid drains.
    do_reset();
    stall = 1'b1;
    repeat (5) step();
    for (int k = 0; k < 3; k++) begin
      chk("stall_req_gated", 32'(imem_req_valid), 32'h0);
      chk("stall_hold_pc", instr_pc, 32'h0);
      step();
    end
    stall = 1'b0;
    repeat (12) step();
    if (got_pc.size() < 3) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_order: only %0d instructions consumed, need 3", got_pc.size());
    end else begin
      chk("stall_order0", got_pc[0], 32'h0);
      chk("stall_order1", got_pc[1], 32'h4);
      chk("stall_order2", got_pc[2], 32'h8);
    end

    // Redirect while waiting on the response for 0x8.
    do_reset();
    lat = 3;
    i = 0;
    while (!(imem_req_valid && imem_addr == 32'h8) && i < 40) begin
      step();
      i++;
    end
    chk("wait_reach_req8", imem_addr, 32'h8);
    step();
    redirect        = 1'b1;
    redirect_target = 32'h100;
    got_pc.delete();
    step();
    redirect = 1'b0;
    repeat (30) step();
    chk_first("wait_redir_first_pc", 32'h100);
    cnt8 = 0;
    foreach (got_pc[j]) if (got_pc[j] == 32'h8) cnt8++;
    chk("wait_redir_no_pc8", 32'(cnt8), 32'h0);

    // Redirect in the same cycle as the accept of 0x4.
    do_reset();
    lat = 1;
    i = 0;
    while (!(imem_req_valid && imem_addr == 32'h4) && i < 40) begin
      step();
      i++;
    end
    chk("acc_reach_req4", imem_addr, 32'h4);
    redirect        = 1'b1;
    redirect_target = 32'h100;
    step();
    redirect = 1'b0;
    got_pc.delete();
    wait_req("acc_redir_req", 20);
    chk("acc_redir_addr", imem_addr, 32'h100);
    repeat (10) step();
    chk_first("acc_redir_first_pc", 32'h100);

    // PC wraps from 0xFFFF_FFFC to 0.
    do_reset();
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    wait_req("wrap_req0", 20);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    wait_req("wrap_req1", 20);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    repeat (6) step();
    chk_first("wrap_first_pc", 32'hFFFF_FFFC);

    // Misaligned redirect target.
    do_reset();
    repeat (4) step();
    redirect        = 1'b1;
    redirect_target = 32'h102;
    step();
    redirect = 1'b0;
    got_pc.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault_set", 32'(fetch_fault), 32'h1);
    for (int k = 0; k < 10; k++) begin
      chk("mis_no_req", 32'(imem_req_valid), 32'h0);
      chk("mis_no_instr", 32'(instr_valid), 32'h0);
      step();
    end
    chk("mis_fault_sticky", 32'(fetch_fault), 32'h1);
    chk("mis_nothing_consumed", 32'(got_pc.size()), 32'h0);
`else
    chk("mis_fault_clear", 32'(fetch_fault), 32'h0);
    wait_req("mis_req", 20);
    chk("mis_masked_addr", imem_addr, 32'h100);
    repeat (10) step();
    chk_first("mis_first_pc", 32'h100);
    chk("mis_fault_still_clear", 32'(fetch_fault), 32'h0);
`endif

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
